aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher that decrypts one 128-bit block with one round per clock, using externally supplied round keys. It sits between the UART receive path, which delivers ciphertext blocks, and the UART transmit path, which consumes plaintext. The block is built from the team's combinational inverse-round primitives: Inv_ShiftRows, Inv_SubBytes, Inv_MixColumns, and a XOR AddRoundKey. The round-key store is an external asynchronous-read register file indexed by this block.

---
 rtl/aes_inv_cipher_iter_if.sv | 21 ++
 rtl/aes_inv_cipher_iter.sv | 133 +++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and data bus between the ciphertext source/key store and the
// iterative AES inverse cipher.
interface aes_inv_cipher_iter_if;
  logic         i_start;
  logic [127:0] i_data;
  logic [3:0]   o_key_idx;
  logic [127:0] i_round_key;
  logic         o_busy;
  logic         o_valid;
  logic [127:0] o_data;

  modport master (
    output i_start, i_data, i_round_key,
    input  o_key_idx, o_busy, o_valid, o_data
  );

  modport slave (
    input  i_start, i_data, i_round_key,
    output o_key_idx, o_busy, o_valid, o_data
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys read
// combinationally from an external key store addressed by o_key_idx.
module aes_inv_cipher_iter #(
  parameter int N_ROUNDS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  aes_inv_cipher_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [3:0] LAST_KEY = 4'(N_ROUNDS);

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic [3:0]   key_idx;
  logic [127:0] ark_w;
  logic [127:0] mc_w;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Inv_ShiftRows is pure wiring: byte (r,c) comes from (r, c-r mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = (((COL - ROW + 4) % 4) * 4) + ROW;
    assign ark_w[127-8*gi -: 8] = inv_sbox(st_q[127-8*SRC -: 8])
                                  ^ bus.i_round_key[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_w[127-32*gi -: 8];
    assign a1 = ark_w[119-32*gi -: 8];
    assign a2 = ark_w[111-32*gi -: 8];
    assign a3 = ark_w[103-32*gi -: 8];
    assign mc_w[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mc_w[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mc_w[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mc_w[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    valid_d = 1'b0;
    key_idx = LAST_KEY;
    case (state_q)
      IDLE: begin
        key_idx = LAST_KEY;
        if (bus.i_start) begin
          st_d    = bus.i_data ^ bus.i_round_key;
          rnd_d   = LAST_KEY - 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        key_idx = rnd_q;
        st_d    = mc_w;
        if (rnd_q == 4'd1) state_d = FINAL;
        else               rnd_d   = rnd_q - 4'd1;
      end
      FINAL: begin
        key_idx = 4'd0;
        data_d  = ark_w;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_key_idx = key_idx;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_valid   = valid_q;
  assign bus.o_data    = data_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed FIPS-197 decrypt vectors against AES-128 and AES-256 instances,
// with the key store modelled as bench-expanded round-key arrays.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk;
  logic rst;
  logic ksel;
  int   checks;
  int   failures;

  logic [127:0] rk_b  [0:15];
  logic [127:0] rk_c  [0:15];
  logic [127:0] rk_14 [0:15];
  logic [127:0] rk_tmp[0:15];

  aes_inv_cipher_iter_if b10();
  aes_inv_cipher_iter_if b14();

  aes_inv_cipher_iter #(.N_ROUNDS(10)) u10 (.i_clk(clk), .i_rst(rst), .bus(b10));
  aes_inv_cipher_iter #(.N_ROUNDS(14)) u14 (.i_clk(clk), .i_rst(rst), .bus(b14));

  assign b10.i_round_key = ksel ? rk_c[b10.o_key_idx] : rk_b[b10.o_key_idx];
  assign b14.i_round_key = rk_14[b14.o_key_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Standard FIPS-197 key expansion; key is left-aligned in 256 bits.
  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w[0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tmp[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks until o_valid, bounded; also counts non-valid cycles with o_busy low.
  task automatic wait_valid(input bit use14, output int cnt, output int busy_low);
    cnt = 0;
    busy_low = 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (use14 ? b14.o_valid : b10.o_valid) break;
      if (!(use14 ? b14.o_busy : b10.o_busy)) busy_low++;
    end
  endtask

  initial begin
    int cnt;
    int cnt2;
    int bl;
    int nval;
    checks   = 0;
    failures = 0;
    ksel     = 1'b0;
    rst      = 1'b0;
    b10.i_start = 1'b0;
    b10.i_data  = '0;
    b14.i_start = 1'b0;
    b14.i_data  = '0;

    expand({KEY_B, 128'h0}, 4, 10);
    for (int r = 0; r < 16; r++) rk_b[r] = rk_tmp[r];
    expand({KEY_C, 128'h0}, 4, 10);
    for (int r = 0; r < 16; r++) rk_c[r] = rk_tmp[r];
    expand(KEY_C3, 8, 14);
    for (int r = 0; r < 16; r++) rk_14[r] = rk_tmp[r];

    #2 rst = 1'b1;
    tick();
    b10.i_start = 1'b1;
    b10.i_data  = CT_B;
    tick();
    chk("rst_start_ignored", 128'(b10.o_busy), 128'd0);
    b10.i_start = 1'b0;
    rst = 1'b0;
    tick();
    chk("reset_busy", 128'(b10.o_busy), 128'd0);
    chk("reset_valid", 128'(b10.o_valid), 128'd0);
    chk("reset_data", b10.o_data, 128'h0);
    chk("reset_key_idx", 128'(b10.o_key_idx), 128'd10);
    chk("reset_key_idx14", 128'(b14.o_key_idx), 128'd14);
    $display("reset: busy=%0d valid=%0d idx=%0d", b10.o_busy, b10.o_valid, b10.o_key_idx);

    // App. B
    ksel = 1'b0;
    b10.i_data  = CT_B;
    b10.i_start = 1'b1;
    tick();
    b10.i_start = 1'b0;
    chk("appb_busy", 128'(b10.o_busy), 128'd1);
    wait_valid(1'b0, cnt, bl);
    chk("appb_latency", 128'(cnt), 128'd10);
    chk("appb_data", b10.o_data, PT_B);
    chk("appb_busy_low_on_valid", 128'(b10.o_busy), 128'd0);
    tick();
    chk("appb_valid_pulse", 128'(b10.o_valid), 128'd0);
    chk("appb_data_hold", b10.o_data, PT_B);
    $display("appb: latency=%0d data=%h", cnt, b10.o_data);

    // App. C.1 with key index sequence
    ksel = 1'b1;
    b10.i_data  = CT_C;
    b10.i_start = 1'b1;
    chk("appc_idx_10", 128'(b10.o_key_idx), 128'd10);
    tick();
    b10.i_start = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      chk($sformatf("appc_idx_%0d", k), 128'(b10.o_key_idx), 128'(k));
      tick();
    end
    chk("appc_valid", 128'(b10.o_valid), 128'd1);
    chk("appc_data", b10.o_data, PT_C);
    $display("appc1: data=%h", b10.o_data);
    tick();

    // Back-to-back with i_start held high
    ksel = 1'b0;
    b10.i_data  = CT_B;
    b10.i_start = 1'b1;
    tick();
    b10.i_data = CT_C;
    wait_valid(1'b0, cnt, bl);
    chk("b2b_first_latency", 128'(cnt), 128'd10);
    chk("b2b_first_data", b10.o_data, PT_B);
    chk("b2b_first_busy_gaps", 128'(bl), 128'd0);
    chk("b2b_busy_low_on_valid", 128'(b10.o_busy), 128'd0);
    ksel = 1'b1;
    wait_valid(1'b0, cnt2, bl);
    b10.i_start = 1'b0;
    chk("b2b_spacing", 128'(cnt2), 128'd11);
    chk("b2b_second_data", b10.o_data, PT_C);
    chk("b2b_second_busy_gaps", 128'(bl), 128'd0);
    $display("b2b: first=%0d spacing=%0d data=%h", cnt, cnt2, b10.o_data);
    tick();
    chk("b2b_idle_after", 128'(b10.o_busy), 128'd0);

    // Busy-ignore
    ksel = 1'b0;
    b10.i_data  = CT_B;
    b10.i_start = 1'b1;
    tick();
    b10.i_start = 1'b0;
    tick(); tick(); tick();
    b10.i_data  = CT_C;
    b10.i_start = 1'b1;
    tick();
    b10.i_start = 1'b0;
    wait_valid(1'b0, cnt, bl);
    chk("busyign_latency", 128'(cnt + 4), 128'd10);
    chk("busyign_data", b10.o_data, PT_B);
    nval = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (b10.o_valid) nval++;
    end
    chk("busyign_no_second_valid", 128'(nval), 128'd0);
    chk("busyign_idle", 128'(b10.o_busy), 128'd0);
    $display("busy_ignore: latency=%0d extra_valids=%0d", cnt + 4, nval);

    // Reset mid-flight at round 5
    ksel = 1'b1;
    b10.i_data  = CT_C;
    b10.i_start = 1'b1;
    tick();
    b10.i_start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("midrst_round5", 128'(b10.o_key_idx), 128'd5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(b10.o_busy), 128'd0);
    chk("midrst_valid", 128'(b10.o_valid), 128'd0);
    chk("midrst_data", b10.o_data, 128'h0);
    chk("midrst_key_idx", 128'(b10.o_key_idx), 128'd10);
    b10.i_start = 1'b1;
    tick();
    chk("midrst_start_ignored", 128'(b10.o_busy), 128'd0);
    b10.i_start = 1'b0;
    rst = 1'b0;
    tick();
    $display("mid_reset: busy=%0d data=%h", b10.o_busy, b10.o_data);
    ksel = 1'b0;
    b10.i_data  = CT_B;
    b10.i_start = 1'b1;
    tick();
    b10.i_start = 1'b0;
    wait_valid(1'b0, cnt, bl);
    chk("postrst_latency", 128'(cnt), 128'd10);
    chk("postrst_data", b10.o_data, PT_B);
    $display("post_reset_appb: latency=%0d data=%h", cnt, b10.o_data);

    // App. C.3 on the 14-round instance
    b14.i_data  = CT_C3;
    b14.i_start = 1'b1;
    tick();
    b14.i_start = 1'b0;
    wait_valid(1'b1, cnt, bl);
    chk("c3_latency", 128'(cnt), 128'd14);
    chk("c3_data", b14.o_data, PT_C);
    $display("appc3: latency=%0d data=%h", cnt, b14.o_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
